id_decode_q: RTL and testbench

Parametrised RV32 instruction-decode stage with a DEPTH-entry queue of decoded bundles between IF and EX. It replaces the fixed single-register ID/EX latch with a valid/ready handshake on both sides, so IF and EX stall independently. It adds illegal-opcode flagging, and it suppresses `reg_wr` when the destination register is x0.

---
 rtl/id_decode_q_if.sv | 33 +++
 rtl/id_decode_q.sv | 134 +++++++++++++
 tb/tb_id_decode_q.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/id_decode_q_if.sv
// id_decode_q_if: IF-side push and EX-side pop handshake bundle for the decode queue.
interface id_decode_q_if #(parameter int ADDR_W = 32, parameter int DEPTH = 2);
  logic                         in_valid;
  logic                         in_ready;
  logic [ADDR_W-1:0]            in_pc;
  logic [31:0]                  in_inst;
  logic                         flush;
  logic                         out_valid;
  logic                         out_ready;
  logic [ADDR_W-1:0]            out_pc;
  logic [31:0]                  out_imm;
  logic [2:0]                   out_aluop;
  logic [1:0]                   out_branch;
  logic [6:0]                   out_ctrl;
  logic [4:0]                   out_rs1;
  logic [4:0]                   out_rs2;
  logic [4:0]                   out_rd;
  logic [2:0]                   out_func3;
  logic [1:0]                   out_func7b;
  logic [7:0]                   out_csr;
  logic                         out_illegal;
  logic [$clog2(DEPTH+1)-1:0]   count;
  modport slave (
    input  in_valid, in_pc, in_inst, flush, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_aluop, out_branch, out_ctrl,
           out_rs1, out_rs2, out_rd, out_func3, out_func7b, out_csr, out_illegal, count
  );
  modport master (
    output in_valid, in_pc, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_aluop, out_branch, out_ctrl,
           out_rs1, out_rs2, out_rd, out_func3, out_func7b, out_csr, out_illegal, count
  );
endinterface

// File: rtl/id_decode_q.sv
// id_decode_q: RV32 decode stage writing decoded bundles into a DEPTH-entry circular queue.
module id_decode_q #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2,
  parameter bit CSR_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  id_decode_q_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       imm;
    logic [2:0]        aluop;
    logic [1:0]        branch;
    logic [6:0]        ctrl;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [2:0]        func3;
    logic [1:0]        func7b;
    logic [7:0]        csr;
    logic              illegal;
  } entry_t;
  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count;
  entry_t          w_dec, w_head;
  logic [31:0]     w_i;
  logic            w_bad, w_ready, w_push, w_pop;
  assign w_i = bus.in_inst;
  always_comb begin
    w_dec = '0;
    w_bad = 1'b0;
    w_dec.pc = bus.in_pc;
    w_dec.func3 = w_i[14:12];
    w_dec.func7b = {w_i[30], w_i[25]};
    w_dec.aluop = 3'd5;
    w_dec.rs1 = w_i[19:15];
    w_dec.rs2 = w_i[24:20];
    w_dec.rd = w_i[11:7];
    case (w_i[6:0])
      7'b0110011: begin w_dec.aluop = 3'd0; w_dec.ctrl = 7'b0001000; end
      7'b0000011: begin
        w_dec.imm = {{20{w_i[31]}}, w_i[31:20]}; w_dec.aluop = 3'd2; w_dec.ctrl = 7'b0011101; w_dec.rs2 = '0;
      end
      7'b0010011: begin
        w_dec.imm = {{20{w_i[31]}}, w_i[31:20]}; w_dec.aluop = 3'd1; w_dec.ctrl = 7'b0011000; w_dec.rs2 = '0;
      end
      7'b1100111: begin
        w_dec.imm = {{20{w_i[31]}}, w_i[31:20]}; w_dec.aluop = 3'd2; w_dec.branch = 2'd3;
        w_dec.ctrl = 7'b0111000; w_dec.rs2 = '0;
      end
      7'b0100011: begin
        w_dec.imm = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]}; w_dec.aluop = 3'd2; w_dec.ctrl = 7'b0010010; w_dec.rd = '0;
      end
      7'b1100011: begin
        w_dec.imm = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
        w_dec.aluop = 3'd3; w_dec.branch = 2'd1; w_dec.rd = '0;
      end
      7'b0110111: begin
        w_dec.imm = {w_i[31:12], 12'h0}; w_dec.aluop = 3'd4; w_dec.ctrl = 7'b0001000; w_dec.rs1 = '0; w_dec.rs2 = '0;
      end
      7'b0010111: begin
        w_dec.imm = {w_i[31:12], 12'h0}; w_dec.aluop = 3'd2; w_dec.ctrl = 7'b1101000; w_dec.rs1 = '0; w_dec.rs2 = '0;
      end
      7'b1101111: begin
        w_dec.imm = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
        w_dec.aluop = 3'd2; w_dec.branch = 2'd2; w_dec.ctrl = 7'b0111000; w_dec.rs1 = '0; w_dec.rs2 = '0;
      end
      7'b1110011: begin
        // func3[2] picks the zimm source; func3==000 splits mret/wfi on func7[4]
        w_dec.imm = {27'b0, w_i[19:15]};
        w_dec.rs2 = '0;
        w_dec.csr = {1'b1, w_i[14] & (w_i[13:12] != 2'b00), w_i[13:12] != 2'b00,
                     w_i[13:12] == 2'b01, w_i[13:12] == 2'b10, w_i[13:12] == 2'b11,
                     (w_i[14:12] == 3'b000) & w_i[29], (w_i[14:12] == 3'b000) & ~w_i[29]};
        w_dec.ctrl = {3'b000, w_i[13:12] != 2'b00, 3'b000};
        w_bad = !CSR_EN;
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_dec.imm = '0;
      w_dec.aluop = 3'd5;
      w_dec.branch = '0;
      w_dec.ctrl = '0;
      w_dec.rs1 = '0;
      w_dec.rs2 = '0;
      w_dec.rd = '0;
      w_dec.csr = '0;
      w_dec.illegal = 1'b1;
    end
    w_dec.ctrl[3] = w_dec.ctrl[3] & (w_dec.rd != 5'd0);
  end
  assign w_ready = r_count != CW'(DEPTH);
  assign w_push = bus.in_valid & w_ready & ~bus.flush;
  assign w_pop = (r_count != '0) & bus.out_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (bus.flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_mem[r_tail] <= w_dec;
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop) r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  assign w_head = r_mem[r_head];
  assign bus.in_ready = w_ready;
  assign bus.out_valid = r_count != '0;
  assign bus.count = r_count;
  assign bus.out_pc = w_head.pc;
  assign bus.out_imm = w_head.imm;
  assign bus.out_aluop = w_head.aluop;
  assign bus.out_branch = w_head.branch;
  assign bus.out_ctrl = w_head.ctrl;
  assign bus.out_rs1 = w_head.rs1;
  assign bus.out_rs2 = w_head.rs2;
  assign bus.out_rd = w_head.rd;
  assign bus.out_func3 = w_head.func3;
  assign bus.out_func7b = w_head.func7b;
  assign bus.out_csr = w_head.csr;
  assign bus.out_illegal = w_head.illegal;
endmodule

// File: tb/tb_id_decode_q.sv
// tb_id_decode_q: directed vectors driven in parallel into DEPTH=2, CSR-less and DEPTH=4 instances.
module tb_id_decode_q;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  int          n_run = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  id_decode_q_if #(.ADDR_W(32), .DEPTH(2)) b2 ();
  id_decode_q_if #(.ADDR_W(32), .DEPTH(2)) b0 ();
  id_decode_q_if #(.ADDR_W(32), .DEPTH(4)) b4 ();
  assign b2.in_valid = in_valid;
  assign b2.in_pc = in_pc;
  assign b2.in_inst = in_inst;
  assign b2.flush = flush;
  assign b2.out_ready = out_ready;
  assign b0.in_valid = in_valid;
  assign b0.in_pc = in_pc;
  assign b0.in_inst = in_inst;
  assign b0.flush = flush;
  assign b0.out_ready = out_ready;
  assign b4.in_valid = in_valid;
  assign b4.in_pc = in_pc;
  assign b4.in_inst = in_inst;
  assign b4.flush = flush;
  assign b4.out_ready = out_ready;
  id_decode_q #(.ADDR_W(32), .DEPTH(2), .CSR_EN(1'b1)) d2 (.clk(clk), .rst(rst), .bus(b2));
  id_decode_q #(.ADDR_W(32), .DEPTH(2), .CSR_EN(1'b0)) d0 (.clk(clk), .rst(rst), .bus(b0));
  id_decode_q #(.ADDR_W(32), .DEPTH(4), .CSR_EN(1'b1)) d4 (.clk(clk), .rst(rst), .bus(b4));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    in_valid = v;
    in_pc = pc;
    in_inst = inst;
  endtask
  initial begin
    #2;
    chk("rst_valid", b2.out_valid, 0);
    chk("rst_ready", b2.in_ready, 1);
    chk("rst_count", b2.count, 0);
    chk("rst_pc", b2.out_pc, 0);
    chk("rst_ctrl", b2.out_ctrl, 0);
    chk("rst_imm", b2.out_imm, 0);
    chk("rst_csr", b2.out_csr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    drive(1, 32'h100, 32'h00500093);
    tick();
    drive(0, 0, 0);
    chk("addi_valid", b2.out_valid, 1);
    chk("addi_imm", b2.out_imm, 5);
    chk("addi_aluop", b2.out_aluop, 1);
    chk("addi_ctrl", b2.out_ctrl, 7'b0011000);
    chk("addi_rd", b2.out_rd, 1);
    chk("addi_rs1", b2.out_rs1, 0);
    chk("addi_rs2", b2.out_rs2, 0);
    chk("addi_pc", b2.out_pc, 32'h100);
    chk("addi_count", b2.count, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("pop_count", b2.count, 0);
    chk("pop_valid", b2.out_valid, 0);
    drive(1, 32'h200, 32'h123452B7);
    tick();
    chk("fill1_ready", b2.in_ready, 1);
    drive(1, 32'h204, 32'h0020A423);
    tick();
    chk("fill2_count", b2.count, 2);
    chk("fill2_ready", b2.in_ready, 0);
    drive(1, 32'h208, 32'hFE208EE3);
    tick();
    chk("full_count", b2.count, 2);
    chk("full_ready", b2.in_ready, 0);
    chk("d4_count3", b4.count, 3);
    chk("lui_pc", b2.out_pc, 32'h200);
    chk("lui_imm", b2.out_imm, 32'h12345000);
    chk("lui_aluop", b2.out_aluop, 4);
    chk("lui_ctrl", b2.out_ctrl, 7'b0001000);
    chk("lui_rd", b2.out_rd, 5);
    out_ready = 1;
    tick();
    chk("drain1_count", b2.count, 1);
    chk("sw_pc", b2.out_pc, 32'h204);
    chk("sw_imm", b2.out_imm, 8);
    chk("sw_ctrl", b2.out_ctrl, 7'b0010010);
    chk("sw_rs1", b2.out_rs1, 1);
    chk("sw_rs2", b2.out_rs2, 2);
    chk("sw_rd", b2.out_rd, 0);
    chk("sw_func3", b2.out_func3, 2);
    tick();
    drive(0, 0, 0);
    chk("beq_count", b2.count, 1);
    chk("beq_pc", b2.out_pc, 32'h208);
    chk("beq_imm", b2.out_imm, 32'hFFFFFFFC);
    chk("beq_branch", b2.out_branch, 1);
    chk("beq_aluop", b2.out_aluop, 3);
    tick();
    out_ready = 0;
    chk("drained", b2.out_valid, 0);
    flush = 1;
    tick();
    flush = 0;
    chk("d4_flushed", b4.count, 0);
    drive(1, 32'h300, 32'h0000006F);
    tick();
    drive(1, 32'h304, 32'h30200073);
    tick();
    drive(0, 0, 0);
    chk("jal_branch", b2.out_branch, 2);
    chk("jal_ctrl", b2.out_ctrl, 7'b0110000);
    chk("jal_rd", b2.out_rd, 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("mret_pc", b2.out_pc, 32'h304);
    chk("mret_csr", b2.out_csr, 8'h82);
    chk("mret_count", b2.count, 1);
    drive(1, 32'h310, 32'h00500093);
    tick();
    chk("preflush_count", b2.count, 2);
    drive(1, 32'h314, 32'hFFFFFFFF);
    flush = 1;
    tick();
    flush = 0;
    drive(0, 0, 0);
    chk("flush_count", b2.count, 0);
    chk("flush_valid", b2.out_valid, 0);
    chk("flush_ready", b2.in_ready, 1);
    tick();
    chk("flush_dropped", b2.count, 0);
    out_ready = 1;
    drive(1, 32'h400, 32'hFFFFFFFF);
    tick();
    chk("ill_flag", b2.out_illegal, 1);
    chk("ill_ctrl", b2.out_ctrl, 0);
    chk("ill_aluop", b2.out_aluop, 5);
    chk("ill_imm", b2.out_imm, 0);
    chk("ill_rd", b2.out_rd, 0);
    drive(1, 32'h404, 32'h34029073);
    tick();
    drive(0, 0, 0);
    chk("nocsr_ill", b0.out_illegal, 1);
    chk("nocsr_rs1", b0.out_rs1, 0);
    chk("nocsr_csr", b0.out_csr, 0);
    chk("nocsr_imm", b0.out_imm, 0);
    chk("csrw_ill", b2.out_illegal, 0);
    chk("csrw_csr", b2.out_csr, 8'hB0);
    chk("csrw_imm", b2.out_imm, 5);
    chk("csrw_rs1", b2.out_rs1, 5);
    chk("csrw_ctrl", b2.out_ctrl, 0);
    tick();
    chk("csr_drained", b2.count, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h500 + 32'(4 * i), {12'(i), 5'd0, 3'b000, 5'd1, 7'b0010011});
      tick();
      chk("wrap_valid", b4.out_valid, 1);
      chk("wrap_pc", b4.out_pc, 32'h500 + 32'(4 * i));
      chk("wrap_imm", b4.out_imm, 64'(i));
      chk("wrap_count", b4.count, 1);
    end
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", b4.out_valid, 0);
    chk("arst_count", b4.count, 0);
    chk("arst_ready", b4.in_ready, 1);
    chk("arst_pc", b4.out_pc, 0);
    drive(0, 0, 0);
    out_ready = 0;
    #2 rst = 1'b1;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
